// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: Wishbone segment between the ramp master and the pwm slave.
// master drives ADR/DAT_O/WE/SEL/STB/CYC; slave returns DAT_I/ACK_I.
interface pwm_ramp_ctrl_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        WE_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I;

  modport master (
    output ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, WE_O, SEL_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: Wishbone master ramping the pwm duty register to a target.
// Ports: CLK_I/RST_I (sync, active-high), start/abort/target/step/interval
// control, wb (master modport), busy/done/err status, cur_duty mirror.
module pwm_ramp_ctrl #(
  parameter logic [31:0] PWM_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          IV_W     = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      target,
  input  logic [31:0]      step,
  input  logic [IV_W-1:0]  interval,
  pwm_ramp_ctrl_if.master  wb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      cur_duty
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GAP_R = 4'd1;
  localparam logic [3:0] S_RD    = 4'd2;
  localparam logic [3:0] S_CALC  = 4'd3;
  localparam logic [3:0] S_GAP_W = 4'd4;
  localparam logic [3:0] S_WR    = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [3:0]      state;
  logic [31:0]     tgt_q;
  logic [31:0]     stp_q;
  logic [31:0]     nxt_q;
  logic [IV_W-1:0] iv_q;
  logic [IV_W-1:0] iv_cnt;
  logic [TW-1:0]   tmo;
  logic            cyc_q;
  logic            we_q;
  logic [31:0]     calc_nxt;
  logic            tmo_hit;

  // Clamp to target whenever the remaining distance fits in one step,
  // so the ramp never wraps or overshoots.
  always_comb begin
    calc_nxt = cur_duty;
    unique case (1'b1)
      (cur_duty < tgt_q):
        calc_nxt = (tgt_q - cur_duty <= stp_q) ?
                   tgt_q : cur_duty + stp_q;
      (cur_duty > tgt_q):
        calc_nxt = (cur_duty - tgt_q <= stp_q) ?
                   tgt_q : cur_duty - stp_q;
      default:
        calc_nxt = cur_duty;
    endcase
  end

  assign tmo_hit = (tmo == TW'(TIMEOUT - 1));

  // Address/select/data are gated so the bus reads as zero between cycles.
  assign wb.CYC_O = cyc_q;
  assign wb.STB_O = cyc_q;
  assign wb.ADR_O = cyc_q ? PWM_ADDR : 32'd0;
  assign wb.SEL_O = cyc_q ? 4'hF : 4'h0;
  assign wb.WE_O  = cyc_q & we_q;
  assign wb.DAT_O = (cyc_q & we_q) ? nxt_q : 32'd0;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= S_IDLE;
      tgt_q    <= '0;
      stp_q    <= '0;
      nxt_q    <= '0;
      iv_q     <= '0;
      iv_cnt   <= '0;
      tmo      <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cur_duty <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              tgt_q <= target;
              stp_q <= (step == 32'd0) ? 32'd1 : step;
              iv_q  <= interval;
              busy  <= 1'b1;
              state <= S_GAP_R;
            end
          end
          // The slave may hold ACK one cycle past STB; wait it out.
          S_GAP_R: begin
            if (!wb.ACK_I) begin
              cyc_q <= 1'b1;
              we_q  <= 1'b0;
              tmo   <= '0;
              state <= S_RD;
            end
          end
          S_RD: begin
            if (wb.ACK_I) begin
              cur_duty <= wb.DAT_I;
              cyc_q    <= 1'b0;
              state    <= S_CALC;
            end else if (tmo_hit) begin
              cyc_q <= 1'b0;
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_CALC: begin
            if (cur_duty == tgt_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              nxt_q <= calc_nxt;
              state <= S_GAP_W;
            end
          end
          S_GAP_W: begin
            if (!wb.ACK_I) begin
              cyc_q <= 1'b1;
              we_q  <= 1'b1;
              tmo   <= '0;
              state <= S_WR;
            end
          end
          S_WR: begin
            if (wb.ACK_I) begin
              cur_duty <= nxt_q;
              cyc_q    <= 1'b0;
              we_q     <= 1'b0;
              if (nxt_q == tgt_q) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else if (iv_q == '0) begin
                state <= S_CALC;
              end else begin
                iv_cnt <= iv_q;
                state  <= S_WAIT;
              end
            end else if (tmo_hit) begin
              cyc_q <= 1'b0;
              we_q  <= 1'b0;
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERR;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          S_WAIT: begin
            if (iv_cnt <= IV_W'(1)) begin
              state <= S_CALC;
            end else begin
              iv_cnt <= iv_cnt - 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
